// File: rtl/alu_seq_pkg.sv
// Shared types and opcode constants for the ALU op sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        FINISH
    } state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] constsel;
    } step_t;

    localparam logic [2:0] OP_IDLE = 3'd0;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;

endpackage

// File: rtl/alu_seq_progmem.sv
// Program store: DEPTH step entries, synchronous write, combinational read.
module alu_seq_progmem
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  step_t         wdata,
    input  logic [AW-1:0] raddr,
    output step_t         rdata
);

    step_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Runs a stored sequence of {op, constsel} steps through the external ALU datapath.
// Define ALU_STATUS_HALT_EN to stop a run early when the ALU raises AluStatus.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ProgWe,
    input  logic [AW-1:0] ProgAddr,
    input  logic [4:0]    ProgData,
    input  logic [AW:0]   ProgLen,
    input  logic          Start,
    input  logic [7:0]    StartValue,
    input  logic [7:0]    AluOutput,
    input  logic          AluStatus,
    output logic [7:0]    AluInput,
    output logic [1:0]    AluConstantSelect,
    output logic [2:0]    AluOperation,
    output logic          Busy,
    output logic          Done,
    output logic [7:0]    Result,
`ifdef ALU_STATUS_HALT_EN
    output logic          Halted,
`endif
    output logic [AW:0]   StepCount
);

    localparam logic [AW:0] DEPTH_LEN = (AW + 1)'(DEPTH);

    state_t      state;
    logic [7:0]  acc;
    logic [AW:0] len;
    logic [AW:0] ptr;
    logic [AW:0] ptr_inc;
    logic [AW:0] len_clamped;
    logic        mem_we;
    logic        halt_now;
    step_t       rd_step;

    assign ptr_inc     = ptr + 1'b1;
    assign len_clamped = (ProgLen > DEPTH_LEN) ? DEPTH_LEN : ProgLen;
    assign mem_we      = ProgWe && (state == IDLE);

`ifdef ALU_STATUS_HALT_EN
    assign halt_now = AluStatus;
`else
    logic unused_status;
    assign unused_status = AluStatus;
    assign halt_now      = 1'b0;
`endif

    alu_seq_progmem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_progmem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (ProgAddr),
        .wdata (step_t'(ProgData)),
        .raddr (ptr[AW-1:0]),
        .rdata (rd_step)
    );

    // Result is loaded on entry to FINISH so it is already valid while Done is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            acc               <= '0;
            len               <= '0;
            ptr               <= '0;
            Result            <= '0;
            StepCount         <= '0;
            Busy              <= 1'b0;
            Done              <= 1'b0;
            AluInput          <= '0;
            AluConstantSelect <= '0;
            AluOperation      <= OP_IDLE;
`ifdef ALU_STATUS_HALT_EN
            Halted            <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        acc       <= StartValue;
                        len       <= len_clamped;
                        ptr       <= '0;
                        StepCount <= '0;
                        Busy      <= 1'b1;
`ifdef ALU_STATUS_HALT_EN
                        Halted    <= 1'b0;
`endif
                        if (ProgLen == '0) begin
                            Result <= StartValue;
                            Done   <= 1'b1;
                            state  <= FINISH;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    AluInput          <= acc;
                    AluOperation      <= rd_step.op;
                    AluConstantSelect <= rd_step.constsel;
                    state             <= CAPTURE;
                end
                CAPTURE: begin
                    acc       <= AluOutput;
                    ptr       <= ptr_inc;
                    StepCount <= StepCount + 1'b1;
                    if ((ptr_inc == len) || halt_now) begin
                        Result <= AluOutput;
                        Done   <= 1'b1;
                        state  <= FINISH;
`ifdef ALU_STATUS_HALT_EN
                        Halted <= halt_now;
`endif
                    end else begin
                        state <= ISSUE;
                    end
                end
                FINISH: begin
                    Result            <= acc;
                    AluOperation      <= OP_IDLE;
                    AluConstantSelect <= '0;
                    Busy              <= 1'b0;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
